// File: rtl/dqn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dqn_pkg
//  Description : Shared types and constants for the DQN datapath. Q-values
//                are signed Q6.10 on 16 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package dqn_pkg;

    localparam int Q_W     = 16;
    localparam int Q_FRAC  = 10;
    localparam int NUM_ACT = 4;
    localparam int ACT_W   = 2;

    // Action-select scan sequencer states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

endpackage : dqn_pkg
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Fibonacci LFSR, taps 16,14,13,11. Shift-left form,
//                feedback enters at bit 0. Seed must be non-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,      // asynchronous, active-low
    input  logic        i_en,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Shift register: reload seed on reset, otherwise step when enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule : lfsr16
`default_nettype wire

// File: rtl/q_action_select.sv
`default_nettype none
// ============================================================================
//  Module      : q_action_select
//  Description : Scans NUM_ACT Q-values one per cycle with a single shared
//                signed comparator and returns argmax/max, with optional
//                epsilon-greedy replacement of the action from an LFSR.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_action_select
    import dqn_pkg::*;
#(
    parameter int          NUM_ACT    = dqn_pkg::NUM_ACT,
    parameter int          ACT_W      = dqn_pkg::ACT_W,
    parameter logic [7:0]  EPS_THRESH = 8'd26,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,        // asynchronous, active-low
    input  logic                   start,
    input  logic                   explore_en,
    input  logic [Q_W*NUM_ACT-1:0] q_vec,
    output logic                   busy,
    output logic                   done,
    output logic [ACT_W-1:0]       act,
    output logic [Q_W-1:0]         qt,
    output logic [Q_W-1:0]         qmax,
    output logic                   explored
);

    // Scan index runs 0..NUM_ACT; the extra count is the cycle that hands
    // the finished running max over to RESULT.
    localparam int                 c_IDX_W   = ACT_W + 1;
    localparam logic [c_IDX_W-1:0] c_IDX_END = c_IDX_W'(NUM_ACT);

    state_t                 r_state;
    state_t                 w_state_next;

    logic signed [Q_W-1:0]  r_qbuf [NUM_ACT];
    logic [c_IDX_W-1:0]     r_idx;
    logic signed [Q_W-1:0]  r_run_max;
    logic [ACT_W-1:0]       r_run_arg;
    logic                   r_explore_flag;
    logic [ACT_W-1:0]       r_rnd_act;

    logic [ACT_W-1:0]       r_act;
    logic [Q_W-1:0]         r_qt;
    logic [Q_W-1:0]         r_qmax;
    logic                   r_explored;

    logic [15:0]            w_lfsr;
    logic                   w_take_start;
    logic                   w_scan_end;
    logic signed [Q_W-1:0]  w_cur;
    logic                   w_gt;
    logic [ACT_W-1:0]       w_act;
    logic                   w_unused;

    lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (1'b1),
        .o_lfsr (w_lfsr)
    );

    // Upper LFSR bits are not consumed for this action width
    assign w_unused = ^w_lfsr[15:ACT_W+8];

    assign w_take_start = (r_state == S_IDLE) && start;
    assign w_scan_end   = (r_state == S_SCAN) && (r_idx == c_IDX_END);

    // Single shared comparator; at idx == NUM_ACT the low bits wrap but the
    // result is not used on that cycle.
    assign w_cur = r_qbuf[r_idx[ACT_W-1:0]];
    assign w_gt  = (w_cur > r_run_max);

    assign w_act = r_explore_flag ? r_rnd_act : r_run_arg;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start)      w_state_next = S_SCAN;
            S_SCAN:   if (w_scan_end) w_state_next = S_RESULT;
            S_RESULT:                 w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SCAN:   busy = 1'b1;
            S_RESULT: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Snapshot on accepted start, then one compare per SCAN cycle;
    // strict greater-than keeps the lowest index on ties
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACT; i++) begin
                r_qbuf[i] <= '0;
            end
            r_idx          <= '0;
            r_run_max      <= '0;
            r_run_arg      <= '0;
            r_explore_flag <= 1'b0;
            r_rnd_act      <= '0;
        end else if (w_take_start) begin
            for (int i = 0; i < NUM_ACT; i++) begin
                r_qbuf[i] <= q_vec[Q_W*i +: Q_W];
            end
            r_idx          <= '0;
            r_explore_flag <= explore_en & (w_lfsr[7:0] < EPS_THRESH);
            r_rnd_act      <= w_lfsr[ACT_W+7:8];
        end else if ((r_state == S_SCAN) && !w_scan_end) begin
            if ((r_idx == '0) || w_gt) begin
                r_run_max <= w_cur;
                r_run_arg <= r_idx[ACT_W-1:0];
            end
            r_idx <= r_idx + 1'b1;
        end
    end

    // Result registers load on entry to RESULT and hold until the next one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_act      <= '0;
            r_qt       <= '0;
            r_qmax     <= '0;
            r_explored <= 1'b0;
        end else if (w_scan_end) begin
            r_act      <= w_act;
            r_qt       <= r_qbuf[w_act];
            r_qmax     <= r_run_max;
            r_explored <= r_explore_flag;
        end
    end

    assign act      = r_act;
    assign qt       = r_qt;
    assign qmax     = r_qmax;
    assign explored = r_explored;

endmodule : q_action_select
`default_nettype wire

// File: tb/tb_q_action_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q_action_select
//  Description : Self-checking bench for q_action_select: table vectors,
//                hand-written multi-cycle sequences and randomized scans
//                against a behavioural argmax/LFSR reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_q_action_select;

    localparam int          c_NA   = 4;
    localparam logic [15:0] c_SEED = 16'hACE1;
    localparam int          c_LAT  = c_NA + 1;   // start edge -> done edge
    localparam int          c_PER  = c_NA + 3;   // IDLE + SCAN(NUM_ACT+1) + RESULT

    logic        clk;
    logic        rst;
    logic        start, start_x;
    logic        explore_en;
    logic [63:0] q_vec;

    logic        busy, done, explored;
    logic [1:0]  act;
    logic [15:0] qt, qmax;
    logic        busy_x, done_x, explored_x;
    logic [1:0]  act_x;
    logic [15:0] qt_x, qmax_x;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    logic [15:0] m_lfsr;

    q_action_select u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .explore_en (explore_en),
        .q_vec      (q_vec),
        .busy       (busy),
        .done       (done),
        .act        (act),
        .qt         (qt),
        .qmax       (qmax),
        .explored   (explored)
    );

    q_action_select #(
        .EPS_THRESH (8'hFF)
    ) u_dut_x (
        .clk        (clk),
        .rst        (rst),
        .start      (start_x),
        .explore_en (explore_en),
        .q_vec      (q_vec),
        .busy       (busy_x),
        .done       (done_x),
        .act        (act_x),
        .qt         (qt_x),
        .qmax       (qmax_x),
        .explored   (explored_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: parity of the tap mask (bits 15,13,12,10) shifted in
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= c_SEED;
        else      m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [63:0] q;
        logic [1:0]  act;
        logic [15:0] qt;
        logic [15:0] qmax;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] qsel(input logic [63:0] qv, input int i);
        return qv[16*i +: 16];
    endfunction

    // Max first, then the lowest index holding that max
    function automatic void ref_argmax(input logic [63:0] qv, output logic [1:0] arg,
                                       output logic [15:0] mx);
        int best;
        best = $signed(qsel(qv, 0));
        for (int i = 1; i < c_NA; i++) begin
            if ($signed(qsel(qv, i)) > best) best = $signed(qsel(qv, i));
        end
        mx  = 16'(best);
        arg = 2'd0;
        for (int i = c_NA - 1; i >= 0; i--) begin
            if (qsel(qv, i) == mx) arg = 2'(i);
        end
    endfunction

    // Called just after a negedge with the target DUT idle; returns at a
    // negedge with the DUT back in IDLE.
    task automatic do_scan(input logic [63:0] qv, input logic en, input bit use_x,
                           output logic [15:0] m_start, output int lat,
                           output logic [1:0] a, output logic [15:0] t,
                           output logic [15:0] mx, output logic ex);
        bit seen;
        q_vec      = qv;
        explore_en = en;
        if (use_x) start_x = 1'b1;
        else       start   = 1'b1;
        m_start = m_lfsr;
        lat  = -1;
        seen = 1'b0;
        a = 'x; t = 'x; mx = 'x; ex = 'x;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            start   = 1'b0;
            start_x = 1'b0;
            if ((use_x ? done_x : done) === 1'b1) begin
                seen = 1'b1;
                lat  = n - 1;
                a    = use_x ? act_x      : act;
                t    = use_x ? qt_x       : qt;
                mx   = use_x ? qmax_x     : qmax;
                ex   = use_x ? explored_x : explored;
            end
        end
        if (!seen) check("scan_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    logic [15:0] ms, t_g, mx_g, e_qmax, e_qt;
    logic [1:0]  a_g, e_act, e_arg;
    logic        ex_g, e_ex, en_r;
    logic [63:0] qv_r;
    int          lat_g, dc0;
    int          dn_at [$];

    initial begin
        tbl[0] = '{q: {16'hFC00, 16'h0800, 16'h0C00, 16'h0400}, act: 2'd1, qt: 16'h0C00, qmax: 16'h0C00};
        tbl[1] = '{q: {16'h0800, 16'h0800, 16'h0800, 16'h0800}, act: 2'd0, qt: 16'h0800, qmax: 16'h0800};
        tbl[2] = '{q: {16'hF000, 16'hF800, 16'hFC00, 16'hF400}, act: 2'd1, qt: 16'hFC00, qmax: 16'hFC00};
        tbl[3] = '{q: {16'h7FFF, 16'h8000, 16'h0000, 16'h0001}, act: 2'd3, qt: 16'h7FFF, qmax: 16'h7FFF};
        tbl[4] = '{q: {16'h0000, 16'h0400, 16'hFC00, 16'h0400}, act: 2'd0, qt: 16'h0400, qmax: 16'h0400};
        tbl[5] = '{q: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, act: 2'd0, qt: 16'h8000, qmax: 16'h8000};

        rst = 1'b0; start = 1'b0; start_x = 1'b0; explore_en = 1'b0; q_vec = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset act", act, 0);
        check("reset qt", qt, 0);
        check("reset qmax", qmax, 0);
        check("reset explored", explored, 0);
        rst = 1'b1;
        @(negedge clk);

        // Greedy table vectors
        foreach (tbl[i]) begin
            do_scan(tbl[i].q, 1'b0, 1'b0, ms, lat_g, a_g, t_g, mx_g, ex_g);
            check($sformatf("tbl%0d latency", i), lat_g, c_LAT);
            check($sformatf("tbl%0d act", i), a_g, tbl[i].act);
            check($sformatf("tbl%0d qt", i), t_g, tbl[i].qt);
            check($sformatf("tbl%0d qmax", i), mx_g, tbl[i].qmax);
            check($sformatf("tbl%0d explored", i), ex_g, 0);
        end

        // Exploration on the always-explore instance
        for (int i = 0; i < 6; i++) begin
            qv_r = {$urandom, $urandom};
            en_r = (i != 5);
            do_scan(qv_r, en_r, 1'b1, ms, lat_g, a_g, t_g, mx_g, ex_g);
            ref_argmax(qv_r, e_arg, e_qmax);
            e_ex  = en_r && (ms[7:0] < 8'hFF);
            e_act = e_ex ? ms[9:8] : e_arg;
            check($sformatf("explore%0d explored", i), ex_g, e_ex);
            check($sformatf("explore%0d act", i), a_g, e_act);
            check($sformatf("explore%0d qt", i), t_g, qsel(qv_r, int'(e_act)));
            check($sformatf("explore%0d qmax", i), mx_g, e_qmax);
        end

        // Start during SCAN and q_vec change after snapshot are ignored
        dc0 = done_cnt;
        q_vec = tbl[0].q; explore_en = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        start = 1'b1; q_vec = {16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
        @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);
        check("busy start ignored done count", done_cnt - dc0, 1);
        check("busy start act", act, 1);
        check("busy start qt", qt, 16'h0C00);
        check("busy start qmax", qmax, 16'h0C00);

        // Asynchronous reset at SCAN idx 2
        dc0 = done_cnt;
        q_vec = tbl[3].q; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midscan reset busy", busy, 0);
        check("midscan reset act", act, 0);
        check("midscan reset qt", qt, 0);
        check("midscan reset qmax", qmax, 0);
        check("midscan reset explored", explored, 0);
        @(negedge clk); rst = 1'b1;
        repeat (10) @(negedge clk);
        check("midscan reset no done", done_cnt - dc0, 0);
        do_scan(tbl[3].q, 1'b0, 1'b0, ms, lat_g, a_g, t_g, mx_g, ex_g);
        check("post reset latency", lat_g, c_LAT);
        check("post reset act", a_g, 3);
        check("post reset qmax", mx_g, 16'h7FFF);

        // Start held high for 20 cycles
        q_vec = tbl[2].q; explore_en = 1'b0; start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 20) start = 1'b0;
            if (done === 1'b1) begin
                dn_at.push_back(n);
                check("b2b act", act, 1);
                check("b2b qmax", qmax, 16'hFC00);
            end
        end
        check("b2b done count", dn_at.size(), 3);
        for (int i = 1; i < dn_at.size(); i++) begin
            check("b2b done spacing", dn_at[i] - dn_at[i-1], c_PER);
        end

        // Randomized scans against the reference model
        for (int it = 0; it < 1000; it++) begin
            for (int i = 0; i < c_NA; i++) begin
                case ($urandom_range(0, 3))
                    0:       qv_r[16*i +: 16] = 16'h0800;
                    1:       qv_r[16*i +: 16] = 16'($urandom_range(0, 3)) - 16'd1;
                    default: qv_r[16*i +: 16] = 16'($urandom);
                endcase
            end
            en_r = 1'($urandom_range(0, 1));
            do_scan(qv_r, en_r, 1'b0, ms, lat_g, a_g, t_g, mx_g, ex_g);
            ref_argmax(qv_r, e_arg, e_qmax);
            e_ex  = en_r && (ms[7:0] < 8'd26);
            e_act = e_ex ? ms[9:8] : e_arg;
            e_qt  = qsel(qv_r, int'(e_act));
            check("rand explored", ex_g, e_ex);
            check("rand act", a_g, e_act);
            check("rand qt", t_g, e_qt);
            check("rand qmax", mx_g, e_qmax);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_q_action_select
`default_nettype wire
